conv_input_interface: RTL and testbench

- Responder end of the convolution-layer controller command/ack protocol.
- Accepts PRELOAD / SHIFT / LOAD commands from the layer controller and fetches image words from the image ROM into a KERNEL_SIZE-row line buffer.
- Presents an ARRAY_SIZE-wide pixel window to the kernel array and returns a single-cycle ack when each command finishes.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_input_interface_if.sv | 26 ++
 rtl/conv_line_buffer.sv | 58 +++++
 rtl/conv_input_interface.sv | 196 +++++++++++++++++++
 tb/tb_conv_input_interface.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared encodings for the convolution-layer command/ack protocol and the
// responder FSM, plus default geometry used to size preload fetches.
package conv_pkg;

  // Command encodings issued by the layer controller
  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  // Acknowledge encodings returned to the layer controller
  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  localparam int KERNEL_SIZE_DEF = 3;
  localparam int IMAGE_SIZE_DEF  = 8;
  localparam int FETCH_PRELOAD   = KERNEL_SIZE_DEF * IMAGE_SIZE_DEF;

  // Number of ROM reads needed to fill every buffered row
  function automatic int fetch_count(input int kernel_size, input int image_size);
    return kernel_size * image_size;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_input_interface_if.sv
// Command/ack, ROM read and window signals between the layer controller side
// (master) and the input interface (slave).
interface conv_input_interface_if #(
  parameter int WIDTH      = 32,
  parameter int ARRAY_SIZE = 6,
  parameter int ADDR_WIDTH = 6
);
  logic [1:0]                  cmd;
  logic [1:0]                  ack;
  logic                        rom_en;
  logic [ADDR_WIDTH-1:0]       rom_addr;
  logic [WIDTH-1:0]            rom_data;
  logic [ARRAY_SIZE*WIDTH-1:0] window;
  logic                        busy;
  logic [ADDR_WIDTH-1:0]       row_ptr;

  modport master (
    output cmd, rom_data,
    input  ack, rom_en, rom_addr, window, busy, row_ptr
  );

  modport slave (
    input  cmd, rom_data,
    output ack, rom_en, rom_addr, window, busy, row_ptr
  );
endinterface

// File: rtl/conv_line_buffer.sv
// KERNEL_SIZE x IMAGE_SIZE pixel store with a single write port, a whole-row
// rotate toward row 0, and a registered tap-selected window of ARRAY_SIZE words.
module conv_line_buffer #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int ARRAY_SIZE  = 6,
  parameter int ROW_W       = 2,
  parameter int COL_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ROW_W-1:0]            wr_row,
  input  logic [COL_W-1:0]            wr_col,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rotate,
  input  logic                        win_load,
  input  logic [ROW_W-1:0]            tap_row,
  input  logic [ROW_W-1:0]            tap_col,
  output logic [ARRAY_SIZE*WIDTH-1:0] window
);

  logic [WIDTH-1:0]            line_mem [KERNEL_SIZE][IMAGE_SIZE];
  logic [ARRAY_SIZE*WIDTH-1:0] win_next;
  logic [ARRAY_SIZE*WIDTH-1:0] window_reg;

  // Rotate rows toward row 0, then land any incoming ROM word (write wins)
  always_ff @(posedge clk) begin
    if (rotate) begin
      for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
        line_mem[k] <= line_mem[k + 1];
      end
    end
    if (wr_en) begin
      line_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Word gi of the window comes from column tap_col+gi of the tapped row
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_tap
    logic [COL_W-1:0] col_idx;
    assign col_idx = COL_W'(tap_col) + COL_W'(gi);
    assign win_next[gi*WIDTH +: WIDTH] = line_mem[tap_row][col_idx];
  end

  // Window only moves when the controller asks for it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_reg <= '0;
    end else if (win_load) begin
      window_reg <= win_next;
    end
  end

  assign window = window_reg;

endmodule

// File: rtl/conv_input_interface.sv
// Responder for PRELOAD/SHIFT/LOAD commands: streams image rows from the ROM
// into the line buffer, steps the window tap, and returns a one-cycle ack.
module conv_input_interface
  import conv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter int ARRAY_SIZE  = 6,
  parameter int ADDR_WIDTH  = 6,
  parameter int ROM_DEPTH   = 64
) (
  input logic                    clk,
  input logic                    rst,
  conv_input_interface_if.slave  bus
);

  localparam int N_PRELOAD = fetch_count(KERNEL_SIZE, IMAGE_SIZE);
  localparam int CNT_W     = idx_width(N_PRELOAD + 1);
  localparam int ROW_W     = idx_width(KERNEL_SIZE);
  localparam int COL_W     = idx_width(IMAGE_SIZE);

  if (IMAGE_SIZE != ARRAY_SIZE + KERNEL_SIZE - 1) begin : g_bad_geometry
    $error("conv_input_interface: IMAGE_SIZE must equal ARRAY_SIZE+KERNEL_SIZE-1");
  end
  if (ROM_DEPTH < IMAGE_SIZE * IMAGE_SIZE) begin : g_bad_rom
    $error("conv_input_interface: ROM_DEPTH too small for the image");
  end

  state_e                state_reg;
  logic [1:0]            ack_reg;
  logic [1:0]            ack_code_reg;
  logic                  rom_en_reg;
  logic [ADDR_WIDTH-1:0] rom_addr_reg;
  logic [ADDR_WIDTH-1:0] row_ptr_reg;
  logic                  busy_reg;
  logic [ROW_W-1:0]      tap_row_reg;
  logic [ROW_W-1:0]      tap_col_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      fetch_len_reg;
  logic [ROW_W-1:0]      iss_row_reg;
  logic [COL_W-1:0]      iss_col_reg;
  logic                  wr_en_reg;
  logic [ROW_W-1:0]      wr_row_reg;
  logic [COL_W-1:0]      wr_col_reg;

  logic [ADDR_WIDTH-1:0] load_row_next;
  logic [ADDR_WIDTH-1:0] row_ptr_next;
  logic [ADDR_WIDTH-1:0] load_base_next;
  logic                  rotate;
  logic                  win_load;

  // Image row to fetch on LOAD and the new top row, both wrapping at the image edge
  always_comb begin
    load_row_next = row_ptr_reg + ADDR_WIDTH'(KERNEL_SIZE);
    if (load_row_next >= ADDR_WIDTH'(IMAGE_SIZE)) begin
      load_row_next = load_row_next - ADDR_WIDTH'(IMAGE_SIZE);
    end
    row_ptr_next = row_ptr_reg + ADDR_WIDTH'(1);
    if (row_ptr_next >= ADDR_WIDTH'(IMAGE_SIZE)) begin
      row_ptr_next = '0;
    end
    load_base_next = load_row_next * ADDR_WIDTH'(IMAGE_SIZE);
  end

  assign rotate   = (state_reg == S_IDLE) && (bus.cmd == CMD_LOAD);
  assign win_load = (state_reg == S_ACK);

  // Command FSM; the write pipeline trails issue by one cycle to match ROM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ack_reg       <= ACK_IDLE;
      ack_code_reg  <= ACK_IDLE;
      rom_en_reg    <= 1'b0;
      rom_addr_reg  <= '0;
      row_ptr_reg   <= '0;
      busy_reg      <= 1'b0;
      tap_row_reg   <= '0;
      tap_col_reg   <= '0;
      cnt_reg       <= '0;
      fetch_len_reg <= '0;
      iss_row_reg   <= '0;
      iss_col_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_row_reg    <= '0;
      wr_col_reg    <= '0;
    end else begin
      ack_reg    <= ACK_IDLE;
      wr_en_reg  <= rom_en_reg;
      wr_row_reg <= iss_row_reg;
      wr_col_reg <= iss_col_reg;
      case (state_reg)
        S_IDLE: begin
          case (bus.cmd)
            CMD_PRELOAD: begin
              row_ptr_reg   <= '0;
              tap_row_reg   <= '0;
              tap_col_reg   <= '0;
              rom_en_reg    <= 1'b1;
              rom_addr_reg  <= '0;
              iss_row_reg   <= '0;
              iss_col_reg   <= '0;
              cnt_reg       <= CNT_W'(1);
              fetch_len_reg <= CNT_W'(N_PRELOAD);
              busy_reg      <= 1'b1;
              ack_code_reg  <= ACK_PRELOAD_FIN;
              state_reg     <= S_FETCH;
            end
            CMD_LOAD: begin
              row_ptr_reg   <= row_ptr_next;
              tap_row_reg   <= '0;
              tap_col_reg   <= '0;
              rom_en_reg    <= 1'b1;
              rom_addr_reg  <= load_base_next;
              iss_row_reg   <= ROW_W'(KERNEL_SIZE - 1);
              iss_col_reg   <= '0;
              cnt_reg       <= CNT_W'(1);
              fetch_len_reg <= CNT_W'(IMAGE_SIZE);
              busy_reg      <= 1'b1;
              ack_code_reg  <= ACK_LOAD_FIN;
              state_reg     <= S_FETCH;
            end
            CMD_SHIFT: begin
              if (tap_col_reg == ROW_W'(KERNEL_SIZE - 1)) begin
                tap_col_reg <= '0;
                if (tap_row_reg == ROW_W'(KERNEL_SIZE - 1)) begin
                  tap_row_reg <= '0;
                end else begin
                  tap_row_reg <= tap_row_reg + ROW_W'(1);
                end
              end else begin
                tap_col_reg <= tap_col_reg + ROW_W'(1);
              end
              ack_code_reg <= ACK_SHIFT_FIN;
              state_reg    <= S_ACK;
            end
            default: ;
          endcase
        end
        S_FETCH: begin
          if (cnt_reg == fetch_len_reg) begin
            rom_en_reg <= 1'b0;
            state_reg  <= S_DRAIN;
          end else begin
            rom_addr_reg <= rom_addr_reg + ADDR_WIDTH'(1);
            cnt_reg      <= cnt_reg + CNT_W'(1);
            if (iss_col_reg == COL_W'(IMAGE_SIZE - 1)) begin
              iss_col_reg <= '0;
              iss_row_reg <= iss_row_reg + ROW_W'(1);
            end else begin
              iss_col_reg <= iss_col_reg + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          state_reg <= S_ACK;
        end
        S_ACK: begin
          ack_reg   <= ack_code_reg;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  conv_line_buffer #(
    .WIDTH       (WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMAGE_SIZE  (IMAGE_SIZE),
    .ARRAY_SIZE  (ARRAY_SIZE),
    .ROW_W       (ROW_W),
    .COL_W       (COL_W)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en_reg),
    .wr_row   (wr_row_reg),
    .wr_col   (wr_col_reg),
    .wr_data  (bus.rom_data),
    .rotate   (rotate),
    .win_load (win_load),
    .tap_row  (tap_row_reg),
    .tap_col  (tap_col_reg),
    .window   (bus.window)
  );

  assign bus.ack      = ack_reg;
  assign bus.rom_en   = rom_en_reg;
  assign bus.rom_addr = rom_addr_reg;
  assign bus.busy     = busy_reg;
  assign bus.row_ptr  = row_ptr_reg;

endmodule

// File: tb/tb_conv_input_interface.sv
// Directed and randomized command sequences against a row/tap reference model.
module tb_conv_input_interface;
  import conv_pkg::*;

  localparam int WIDTH = 32;
  localparam int K     = 3;
  localparam int IMG   = 8;
  localparam int ARR   = 6;
  localparam int AW    = 6;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: buffer row k holds image row (m_row_ptr+k) mod IMG,
  // tap is a linear index 0..K*K-1 over (row, col)
  int m_row_ptr = 0;
  int m_tap     = 0;

  conv_input_interface_if #(.WIDTH(WIDTH), .ARRAY_SIZE(ARR), .ADDR_WIDTH(AW)) bus ();

  conv_input_interface #(
    .WIDTH(WIDTH), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG),
    .ARRAY_SIZE(ARR), .ADDR_WIDTH(AW), .ROM_DEPTH(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image ROM: word a holds value a, one cycle read latency
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= WIDTH'(bus.rom_addr);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_window();
    logic [255:0] w;
    int r;
    w = '0;
    r = (m_row_ptr + m_tap / K) % IMG;
    for (int i = 0; i < ARR; i++) begin
      w[i*WIDTH +: WIDTH] = WIDTH'(r * IMG + (m_tap % K) + i);
    end
    return w;
  endfunction

  // Issue one command from a negedge, wait for its ack, check everything
  task automatic issue(input logic [1:0] c, input bit inject);
    int lat;
    int exp_lat;
    int exp_n;
    int base;
    int addrs[$];
    case (c)
      CMD_PRELOAD: begin exp_lat = FETCH_PRELOAD + 2; exp_n = FETCH_PRELOAD; base = 0; end
      CMD_LOAD:    begin exp_lat = IMG + 2; exp_n = IMG; base = ((m_row_ptr + K) % IMG) * IMG; end
      default:     begin exp_lat = 1; exp_n = 0; base = 0; end
    endcase
    bus.cmd = c;
    @(posedge clk);
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    lat = 0;
    check("busy_after_cmd", 256'(bus.busy), 256'(c != CMD_SHIFT));
    while (bus.ack == ACK_IDLE && lat < 100) begin
      if (bus.rom_en) addrs.push_back(int'(bus.rom_addr));
      if (inject) begin
        case (lat)
          5: bus.cmd = CMD_SHIFT;
          6: bus.cmd = CMD_IDLE;
          8: bus.cmd = CMD_LOAD;
          9: bus.cmd = CMD_IDLE;
          default: ;
        endcase
      end
      @(negedge clk);
      lat++;
    end
    case (c)
      CMD_PRELOAD: begin m_row_ptr = 0; m_tap = 0; end
      CMD_LOAD:    begin m_row_ptr = (m_row_ptr + 1) % IMG; m_tap = 0; end
      default:     m_tap = (m_tap + 1) % (K * K);
    endcase
    check("ack_code", 256'(bus.ack), 256'(c));
    check("ack_latency", 256'(lat), 256'(exp_lat));
    check("busy_at_ack", 256'(bus.busy), 256'(0));
    check("rom_read_count", 256'(addrs.size()), 256'(exp_n));
    foreach (addrs[i]) check("rom_addr", 256'(addrs[i]), 256'(base + i));
    check("window", bus.window, model_window());
    check("row_ptr", 256'(bus.row_ptr), 256'(m_row_ptr));
    $display("[TB] cmd=%0d ack=%0d lat=%0d reads=%0d row_ptr=%0d window=%h",
             c, bus.ack, lat, addrs.size(), bus.row_ptr, bus.window);
    @(negedge clk);
    check("ack_width", 256'(bus.ack), 256'(0));
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int acks;
    acks = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.ack != ACK_IDLE) acks++;
    end
    check(tag, 256'(acks), 256'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 256'(bus.ack), 256'(0));
    check({tag, "_rom_en"}, 256'(bus.rom_en), 256'(0));
    check({tag, "_rom_addr"}, 256'(bus.rom_addr), 256'(0));
    check({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check({tag, "_row_ptr"}, 256'(bus.row_ptr), 256'(0));
    check({tag, "_window"}, 256'(bus.window), 256'(0));
  endtask

  initial begin
    logic [1:0] c;
    rst = 1'b1;
    bus.cmd = CMD_IDLE;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    $display("[TB] reset state checked");
    rst = 1'b0;
    @(negedge clk);

    // PRELOAD, then walk the tap through a full cycle
    issue(CMD_PRELOAD, 1'b0);
    issue(CMD_SHIFT, 1'b0);
    repeat (2) issue(CMD_SHIFT, 1'b0);
    repeat (6) issue(CMD_SHIFT, 1'b0);

    // Two LOADs after a fresh PRELOAD
    issue(CMD_PRELOAD, 1'b0);
    issue(CMD_LOAD, 1'b0);
    issue(CMD_LOAD, 1'b0);

    // Commands pulsed mid-fetch must be dropped
    issue(CMD_PRELOAD, 1'b1);
    check_quiet("no_queued_ack", 14);

    // Reset in the middle of a PRELOAD fetch
    bus.cmd = CMD_PRELOAD;
    @(posedge clk);
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    repeat (9) @(negedge clk);
    check("fetch_active", 256'(bus.rom_en), 256'(1));
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    $display("[TB] reset asserted mid-preload");
    @(negedge clk);
    rst = 1'b0;
    m_row_ptr = 0;
    m_tap = 0;
    check_quiet("no_ack_after_abort", 30);
    issue(CMD_PRELOAD, 1'b0);

    // Controller-style random command stream
    for (int n = 0; n < 60; n++) begin
      c = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (c == CMD_IDLE) begin
        check_quiet("idle_cmd_no_ack", 3);
        $display("[TB] cmd=0 idle");
      end else begin
        issue(c, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
